// File: rtl/note_sequencer.sv
// note_sequencer: walks a song held in a synchronous-read memory and drives
// the 27-bit three-voice notes bus for a programmed number of tempo ticks per
// event. Handles tempo timing, event fetch, end-of-song/loop and play/stop.
// Optional build macro NOTE_SEQUENCER_GAP_EN inserts a one-tick articulation
// gap (note bits zeroed, waveform bits kept) after every held event.
module note_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int TICK_DIV   = 12500,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic [26:0]       notes,
  output logic              playing,
  output logic              song_done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] START      = ADDR_W'(START_ADDR);
`ifdef NOTE_SEQUENCER_GAP_EN
  // Waveform-select bits of the three voices; note bits are cleared.
  localparam logic [26:0]       GAP_MASK   = 27'h6030180;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_HOLD
`ifdef NOTE_SEQUENCER_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [4:0]          dur_q, dur_d;
  logic [26:0]         notes_d;
  logic                song_done_d;
  logic [4:0]          duration;

  assign duration = mem_data[31:27];
  assign mem_addr = addr_q;

  // Next-state and next-register-value logic for the sequencer FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d     = state_q;
    addr_d      = addr_q;
    tick_d      = tick_q;
    dur_d       = dur_q;
    notes_d     = notes;
    song_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        notes_d = '0;
        if (play && !stop) state_d = S_FETCH;
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        if (duration != 5'd0) begin
          notes_d = mem_data[26:0];
          dur_d   = duration;
          tick_d  = '0;
          addr_d  = addr_q + 1'b1;  // wraps modulo 2^ADDR_W
          state_d = S_HOLD;
        end else if (loop) begin
          // Restart the song; the last event keeps sounding across the refetch.
          addr_d  = START;
          state_d = S_FETCH;
        end else begin
          notes_d     = '0;
          song_done_d = 1'b1;
          addr_d      = START;
          state_d     = S_IDLE;
        end
      end

      S_HOLD: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          dur_d  = dur_q - 1'b1;
          if (dur_q == 5'd1) begin
`ifdef NOTE_SEQUENCER_GAP_EN
            notes_d = notes & GAP_MASK;
            state_d = S_GAP;
`else
            state_d = S_FETCH;
`endif
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

`ifdef NOTE_SEQUENCER_GAP_EN
      S_GAP: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = S_FETCH;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // stop overrides every other decision made above in the same cycle.
    if (stop && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      notes_d     = '0;
      addr_d      = START;
      tick_d      = '0;
      dur_d       = '0;
      song_done_d = 1'b0;
    end
  end

  // State and output registers; outputs derive from next-state so none is combinational.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= START;
      tick_q    <= '0;
      dur_q     <= '0;
      notes     <= '0;
      mem_en    <= 1'b0;
      playing   <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tick_q    <= tick_d;
      dur_q     <= dur_d;
      notes     <= notes_d;
      mem_en    <= (state_d == S_FETCH);
      playing   <= (state_d != S_IDLE);
      song_done <= song_done_d;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed testbench for note_sequencer with TICK_DIV=4, ADDR_W=2.
// Works with or without NOTE_SEQUENCER_GAP_EN defined.
module tb_note_sequencer;

  localparam int AW   = 2;
  localparam int TICK = 4;
`ifdef NOTE_SEQUENCER_GAP_EN
  localparam logic [26:0] GAP_MASK = 27'h6030180;
`endif

  logic          clk;
  logic          reset;
  logic          play;
  logic          stop;
  logic          loop;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic [26:0]   notes;
  logic          playing;
  logic          song_done;

  logic [31:0]   mem [4];

  int checks = 0;
  int errors = 0;

  note_sequencer #(
    .ADDR_W    (AW),
    .TICK_DIV  (TICK),
    .START_ADDR(0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .stop     (stop),
    .loop     (loop),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .notes    (notes),
    .playing  (playing),
    .song_done(song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read song memory: data valid the cycle after mem_en.
  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ev(input int dur, input logic [26:0] n);
    logic [4:0] d;
    d = 5'(dur);
    return {d, n};
  endfunction

  // Value notes keeps during the refetch after an event ends.
  function automatic logic [26:0] hold_val(input logic [26:0] v);
`ifdef NOTE_SEQUENCER_GAP_EN
    return v & GAP_MASK;
`else
    return v;
`endif
  endfunction

  // From IDLE: pulse play, check FETCH and DECODE, end on the first event cycle.
  task automatic start_play(input string name);
    play = 1'b1;
    tick();
    play = 1'b0;
    check(mem_en === 1'b1 && mem_addr === 2'd0 && playing === 1'b1,
          $sformatf("%s_fetch: mem_en=%b mem_addr=%0d playing=%b, want 1 0 1",
                    name, mem_en, mem_addr, playing));
    tick();
    check(mem_en === 1'b0 && playing === 1'b1 && notes === 27'h0,
          $sformatf("%s_decode: mem_en=%b playing=%b notes=%h, want 0 1 0",
                    name, mem_en, playing, notes));
    tick();
  endtask

  // Positioned at the first cycle an event is visible: check hold length,
  // optional gap, the following FETCH/DECODE, and leave after DECODE.
  task automatic play_event(input string name, input logic [26:0] exp, input int dur,
                            input logic [AW-1:0] next_addr);
    int n;
    check(notes === exp, $sformatf("%s_notes: got %h want %h", name, notes, exp));
    n = 0;
    while (notes === exp && mem_en === 1'b0 && n < 200) begin n++; tick(); end
    check(n == dur * TICK,
          $sformatf("%s_hold: held %0d cycles want %0d", name, n, dur * TICK));
`ifdef NOTE_SEQUENCER_GAP_EN
    n = 0;
    while (notes === (exp & GAP_MASK) && mem_en === 1'b0 && n < 200) begin n++; tick(); end
    check(n == TICK, $sformatf("%s_gap: gap %0d cycles want %0d", name, n, TICK));
`endif
    check(mem_en === 1'b1 && mem_addr === next_addr && notes === hold_val(exp),
          $sformatf("%s_refetch: mem_en=%b addr=%0d notes=%h want 1 %0d %h",
                    name, mem_en, mem_addr, notes, next_addr, hold_val(exp)));
    tick();
    check(mem_en === 1'b0 && notes === hold_val(exp),
          $sformatf("%s_redecode: mem_en=%b notes=%h want 0 %h",
                    name, mem_en, notes, hold_val(exp)));
    tick();
  endtask

  task automatic expect_done(input string name);
    check(notes === 27'h0 && song_done === 1'b1 && playing === 1'b0 && mem_addr === 2'd0,
          $sformatf("%s_end: notes=%h song_done=%b playing=%b addr=%0d want 0 1 0 0",
                    name, notes, song_done, playing, mem_addr));
    tick();
    check(song_done === 1'b0 && playing === 1'b0,
          $sformatf("%s_after_end: song_done=%b playing=%b want 0 0",
                    name, song_done, playing));
  endtask

  task automatic abort();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; play = 1'b1; stop = 1'b0; loop = 1'b0;
    repeat (3) tick();
    play  = 1'b0;
    reset = 1'b0;
    check(notes === 27'h0 && mem_en === 1'b0 && mem_addr === 2'd0 && playing === 1'b0
          && song_done === 1'b0,
          $sformatf("reset: notes=%h mem_en=%b addr=%0d playing=%b done=%b want all 0",
                    notes, mem_en, mem_addr, playing, song_done));
    tick();
    check(playing === 1'b0 && mem_en === 1'b0,
          $sformatf("reset_idle: playing=%b mem_en=%b want 0 0", playing, mem_en));
  endtask

  task automatic test_single_event();
    mem[0] = ev(2, 27'h0000041);
    mem[1] = 32'h0;
    start_play("single");
    play_event("single_ev", 27'h0000041, 2, 2'd1);
    expect_done("single");
  endtask

  task automatic test_two_events();
    mem[0] = ev(1, 27'h1234567);
    mem[1] = ev(3, 27'h0ABCDEF);
    mem[2] = 32'h0;
    start_play("two");
    play_event("two_ev0", 27'h1234567, 1, 2'd1);
    play_event("two_ev1", 27'h0ABCDEF, 3, 2'd2);
    expect_done("two");
  endtask

  task automatic test_loop();
    mem[0] = ev(1, 27'h1111111);
    mem[1] = ev(2, 27'h2222222);
    mem[2] = 32'h0;
    loop = 1'b1;
    start_play("loop");
    for (int r = 0; r < 2; r++) begin
      play_event("loop_ev0", 27'h1111111, 1, 2'd1);
      play_event("loop_ev1", 27'h2222222, 2, 2'd2);
      check(mem_en === 1'b1 && mem_addr === 2'd0 && song_done === 1'b0
            && notes === hold_val(27'h2222222),
            $sformatf("loop_restart: mem_en=%b addr=%0d done=%b notes=%h want 1 0 0 %h",
                      mem_en, mem_addr, song_done, notes, hold_val(27'h2222222)));
      tick();
      tick();
    end
    loop = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check(playing === 1'b0 && notes === 27'h0 && song_done === 1'b0,
          $sformatf("loop_stop: playing=%b notes=%h done=%b want 0 0 0",
                    playing, notes, song_done));
    tick();
  endtask

  task automatic test_stop();
    mem[0] = ev(3, 27'h3333333);
    mem[1] = ev(1, 27'h4444444);
    mem[2] = 32'h0;
    start_play("stop");
    repeat (5) tick();
    stop = 1'b1;
    play = 1'b1;
    tick();
    check(notes === 27'h0 && playing === 1'b0 && mem_en === 1'b0 && song_done === 1'b0
          && mem_addr === 2'd0,
          $sformatf("stop_hold: notes=%h playing=%b mem_en=%b done=%b addr=%0d want 0 0 0 0 0",
                    notes, playing, mem_en, song_done, mem_addr));
    tick();
    check(playing === 1'b0 && mem_en === 1'b0,
          $sformatf("stop_over_play: playing=%b mem_en=%b want 0 0", playing, mem_en));
    stop = 1'b0;
    play = 1'b0;
    tick();
    start_play("stop_restart");
    play_event("stop_restart_ev0", 27'h3333333, 3, 2'd1);
    abort();
  endtask

  task automatic test_stop_in_decode();
    mem[0] = 32'h0;
    play = 1'b1;
    tick();
    play = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check(song_done === 1'b0 && playing === 1'b0,
          $sformatf("stop_decode: done=%b playing=%b want 0 0", song_done, playing));
    tick();
    check(song_done === 1'b0, $sformatf("stop_decode_late: done=%b want 0", song_done));
    start_play("empty");
    expect_done("empty");
  endtask

  task automatic test_play_held();
    mem[0] = ev(1, 27'h0000055);
    mem[1] = 32'h0;
    play = 1'b1;
    tick();
    tick();
    tick();
    play_event("held_ev0", 27'h0000055, 1, 2'd1);
    check(song_done === 1'b1 && playing === 1'b0 && notes === 27'h0,
          $sformatf("held_end: done=%b playing=%b notes=%h want 1 0 0",
                    song_done, playing, notes));
    tick();
    check(mem_en === 1'b1 && playing === 1'b1 && mem_addr === 2'd0 && song_done === 1'b0,
          $sformatf("held_restart: mem_en=%b playing=%b addr=%0d done=%b want 1 1 0 0",
                    mem_en, playing, mem_addr, song_done));
    play = 1'b0;
    abort();
  endtask

  task automatic test_addr_wrap();
    mem[0] = ev(1, 27'h04000A0);
    mem[1] = ev(1, 27'h00200B1);
    mem[2] = ev(1, 27'h10000C2);
    mem[3] = ev(1, 27'h00040D3);
    start_play("wrap");
    play_event("wrap_ev0", 27'h04000A0, 1, 2'd1);
    play_event("wrap_ev1", 27'h00200B1, 1, 2'd2);
    play_event("wrap_ev2", 27'h10000C2, 1, 2'd3);
    play_event("wrap_ev3", 27'h00040D3, 1, 2'd0);
    play_event("wrap_replay", 27'h04000A0, 1, 2'd1);
    abort();
  endtask

`ifdef NOTE_SEQUENCER_GAP_EN
  task automatic test_gap();
    mem[0] = ev(1, 27'h7FFFFFF);
    mem[1] = 32'h0;
    start_play("gap");
    repeat (TICK) tick();
    check(notes === 27'h6030180 && mem_en === 1'b0,
          $sformatf("gap_value: notes=%h mem_en=%b want 6030180 0", notes, mem_en));
    repeat (TICK) tick();
    check(mem_en === 1'b1, $sformatf("gap_fetch: mem_en=%b want 1", mem_en));
    tick();
    tick();
    expect_done("gap");
  endtask
`endif

  initial begin
    play = 1'b0; stop = 1'b0; loop = 1'b0; reset = 1'b1;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    test_reset();
    test_single_event();
    test_two_events();
    test_loop();
    test_stop();
    test_stop_in_decode();
    test_play_held();
    test_addr_wrap();
`ifdef NOTE_SEQUENCER_GAP_EN
    test_gap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
